// File: rtl/msrv32_fetch_pkg.sv
// msrv32 fetch sequencer shared types and default sizing.
// Optional timeout build switch: MSRV32_FETCH_TIMEOUT_EN.
package msrv32_fetch_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_NEXT = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_STALL,
        ST_TRAP
    } fetch_state_t;

    localparam int DEF_BOOT_CYCLES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/msrv32_stall_timer.sv
// Saturating AHB wait-state counter for the fetch sequencer.
// Present only in builds with MSRV32_FETCH_TIMEOUT_EN.
module msrv32_stall_timer
    import msrv32_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic incr_in,
    output logic expired_out
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (clear_in) begin
            cnt <= '0;
        end else if (incr_in && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired_out = (cnt == LIMIT);

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// msrv32 PC sequencer: boot, wait states, trap entry and mret redirects.
// Define MSRV32_FETCH_TIMEOUT_EN to raise fetch_err_out on AHB timeout.
module msrv32_fetch_ctrl
    import msrv32_fetch_pkg::*;
#(
    parameter int BOOT_CYCLES    = DEF_BOOT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ahb_ready_in,
    input  logic       branch_taken_in,
    input  logic       trap_taken_in,
    input  logic       mret_in,
    input  logic       misaligned_instr_in,
    output logic [1:0] pc_src_out,
    output logic       pc_wr_en_out,
    output logic       epc_save_out,
    output logic       flush_out,
    output logic       instr_valid_out,
    output logic       stall_out,
    output logic       misaligned_trap_out,
    output logic       fetch_err_out
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    fetch_state_t state, state_nxt;
    pc_src_t      pc_src;
    logic [3:0]   boot_cnt, boot_cnt_nxt;
    logic         flush_d, valid_d;
    logic         tmo_expired;

`ifdef MSRV32_FETCH_TIMEOUT_EN
    logic tmo_clear, tmo_incr;

    // The counter is zero in RUN, so the first wait cycle counts as one.
    assign tmo_incr  = ((state == ST_RUN) || (state == ST_STALL))
                       && !trap_taken_in && !ahb_ready_in;
    assign tmo_clear = (state == ST_STALL)
                       && (trap_taken_in || ahb_ready_in || tmo_expired);

    msrv32_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (tmo_clear),
        .incr_in    (tmo_incr),
        .expired_out(tmo_expired)
    );
`else
    logic unused_tmo;

    assign unused_tmo  = (TIMEOUT_CYCLES == 0);
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= ST_BOOT;
            boot_cnt        <= BOOT_INIT;
            flush_out       <= 1'b1;
            instr_valid_out <= 1'b0;
        end else begin
            state           <= state_nxt;
            boot_cnt        <= boot_cnt_nxt;
            flush_out       <= flush_d;
            instr_valid_out <= valid_d;
        end
    end

    always_comb begin
        state_nxt    = state;
        boot_cnt_nxt = boot_cnt;
        unique case (state)
            ST_BOOT: begin
                if (boot_cnt == 4'd0) state_nxt = ST_RUN;
                else boot_cnt_nxt = boot_cnt - 4'd1;
            end
            ST_RUN: begin
                if (trap_taken_in) state_nxt = ST_TRAP;
                else if (!ahb_ready_in) state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (trap_taken_in) state_nxt = ST_TRAP;
                else if (ahb_ready_in) state_nxt = ST_RUN;
                else if (tmo_expired) state_nxt = ST_TRAP;
            end
            ST_TRAP: begin
                if (ahb_ready_in) state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_src              = PC_BOOT;
        pc_wr_en_out        = 1'b0;
        epc_save_out        = 1'b0;
        stall_out           = 1'b0;
        misaligned_trap_out = 1'b0;
        fetch_err_out       = 1'b0;
        flush_d             = 1'b0;
        valid_d             = 1'b0;
        if (rst_in) begin
            unique case (state)
                ST_BOOT: begin
                    pc_wr_en_out = 1'b1;
                    flush_d      = 1'b1;
                end
                ST_RUN: begin
                    pc_src = PC_NEXT;
                    if (trap_taken_in) begin
                        epc_save_out = 1'b1;
                    end else if (!ahb_ready_in) begin
                        stall_out = 1'b1;
                    end else if (misaligned_instr_in && branch_taken_in) begin
                        misaligned_trap_out = 1'b1;
                    end else if (mret_in) begin
                        pc_src       = PC_EPC;
                        pc_wr_en_out = 1'b1;
                        flush_d      = 1'b1;
                    end else begin
                        pc_wr_en_out = 1'b1;
                        flush_d      = branch_taken_in;
                        valid_d      = !branch_taken_in;
                    end
                end
                ST_STALL: begin
                    pc_src    = PC_NEXT;
                    stall_out = 1'b1;
                    if (trap_taken_in) begin
                        epc_save_out = 1'b1;
                    end else if (ahb_ready_in) begin
                        stall_out    = 1'b0;
                        pc_wr_en_out = 1'b1;
                        valid_d      = 1'b1;
                    end else if (tmo_expired) begin
                        epc_save_out  = 1'b1;
                        fetch_err_out = 1'b1;
                    end
                end
                ST_TRAP: begin
                    pc_src       = PC_TRAP;
                    pc_wr_en_out = ahb_ready_in;
                    flush_d      = ahb_ready_in;
                end
            endcase
        end
    end

    assign pc_src_out = pc_src;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Self-checking bench for msrv32_fetch_ctrl (BOOT_CYCLES=2, TIMEOUT_CYCLES=4).
// Follows MSRV32_FETCH_TIMEOUT_EN to choose the timeout expectations.
module tb_msrv32_fetch_ctrl;

    // in : {rst, ready, branch, trap, mret, misaligned}
    // cmb: {pc_src[1:0], wr_en, epc_save, stall, mis_trap, fetch_err}
    // rg : {flush, valid} after the edge
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] cmb;
        logic [1:0] rg;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       ahb_ready_in = 1'b0;
    logic       branch_taken_in = 1'b0;
    logic       trap_taken_in = 1'b0;
    logic       mret_in = 1'b0;
    logic       misaligned_instr_in = 1'b0;
    logic [1:0] pc_src_out;
    logic       pc_wr_en_out;
    logic       epc_save_out;
    logic       flush_out;
    logic       instr_valid_out;
    logic       stall_out;
    logic       misaligned_trap_out;
    logic       fetch_err_out;

    int         n_chk = 0;
    int         n_fail = 0;
    int         fe_pulses = 0;
    logic [1:0] sb_q[$];
    vec_t       tbl[35];

    msrv32_fetch_ctrl #(
        .BOOT_CYCLES   (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ahb_ready_in       (ahb_ready_in),
        .branch_taken_in    (branch_taken_in),
        .trap_taken_in      (trap_taken_in),
        .mret_in            (mret_in),
        .misaligned_instr_in(misaligned_instr_in),
        .pc_src_out         (pc_src_out),
        .pc_wr_en_out       (pc_wr_en_out),
        .epc_save_out       (epc_save_out),
        .flush_out          (flush_out),
        .instr_valid_out    (instr_valid_out),
        .stall_out          (stall_out),
        .misaligned_trap_out(misaligned_trap_out),
        .fetch_err_out      (fetch_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input string nm, input int row, input vec_t v);
        logic [6:0] got;
        logic [1:0] want_rg;
        @(negedge clk_in);
        {rst_in, ahb_ready_in, branch_taken_in,
         trap_taken_in, mret_in, misaligned_instr_in} = v.in;
        #1;
        got = {pc_src_out, pc_wr_en_out, epc_save_out,
               stall_out, misaligned_trap_out, fetch_err_out};
        if (fetch_err_out) fe_pulses++;
        n_chk++;
        if (got !== v.cmb) begin
            n_fail++;
            $display("FAIL %s row %0d comb: got %b want %b",
                     nm, row, got, v.cmb);
        end
        sb_q.push_back(v.rg);
        @(posedge clk_in);
        #1;
        want_rg = sb_q.pop_front();
        n_chk++;
        if ({flush_out, instr_valid_out} !== want_rg) begin
            n_fail++;
            $display("FAIL %s row %0d flush/valid: got %b%b want %b",
                     nm, row, flush_out, instr_valid_out, want_rg);
        end
        n_chk++;
        if (flush_out && instr_valid_out) begin
            n_fail++;
            $display("FAIL %s row %0d exclusive: flush=1 valid=1 want not both",
                     nm, row);
        end
    endtask

    initial begin
        vec_t v;
        int   exp_pulses;

        tbl[0]  = '{6'b000000, 7'b00_00000, 2'b10};
        tbl[1]  = '{6'b000000, 7'b00_00000, 2'b10};
        tbl[2]  = '{6'b000000, 7'b00_00000, 2'b10};
        tbl[3]  = '{6'b110000, 7'b00_10000, 2'b10};
        tbl[4]  = '{6'b110000, 7'b00_10000, 2'b10};
        tbl[5]  = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[6]  = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[7]  = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[8]  = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[9]  = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[10] = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[11] = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[12] = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[13] = '{6'b110010, 7'b01_10000, 2'b10};
        tbl[14] = '{6'b111000, 7'b11_10000, 2'b10};
        tbl[15] = '{6'b111001, 7'b11_00010, 2'b00};
        tbl[16] = '{6'b110100, 7'b11_01000, 2'b00};
        tbl[17] = '{6'b100100, 7'b10_00000, 2'b00};
        tbl[18] = '{6'b110000, 7'b10_10000, 2'b10};
        tbl[19] = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[20] = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[21] = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[22] = '{6'b100000, 7'b11_00100, 2'b00};
        tbl[23] = '{6'b100110, 7'b11_01100, 2'b00};
        tbl[24] = '{6'b110010, 7'b10_10000, 2'b10};
        tbl[25] = '{6'b110000, 7'b11_10000, 2'b01};
        tbl[26] = '{6'b110001, 7'b11_10000, 2'b01};
        tbl[27] = '{6'b100100, 7'b11_01000, 2'b00};
        tbl[28] = '{6'b110000, 7'b10_10000, 2'b10};
        tbl[29] = '{6'b100010, 7'b11_00100, 2'b00};
        tbl[30] = '{6'b110010, 7'b11_10000, 2'b01};
        tbl[31] = '{6'b010000, 7'b00_00000, 2'b10};
        tbl[32] = '{6'b110100, 7'b00_10000, 2'b10};
        tbl[33] = '{6'b110000, 7'b00_10000, 2'b10};
        tbl[34] = '{6'b110000, 7'b11_10000, 2'b01};

        for (int i = 0; i < 35; i++) begin
            step("table", i, tbl[i]);
        end

        // Endless wait state starting from RUN.
        fe_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            v.in = 6'b100000;
            v.rg = 2'b00;
`ifdef MSRV32_FETCH_TIMEOUT_EN
            if (i < 4) v.cmb = 7'b11_00100;
            else if (i == 4) v.cmb = 7'b11_01101;
            else v.cmb = 7'b10_00000;
`else
            v.cmb = 7'b11_00100;
`endif
            step("timeout", i, v);
        end
`ifdef MSRV32_FETCH_TIMEOUT_EN
        exp_pulses = 1;
        v = '{6'b110000, 7'b10_10000, 2'b10};
`else
        exp_pulses = 0;
        v = '{6'b110000, 7'b11_10000, 2'b01};
`endif
        n_chk++;
        if (fe_pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL timeout pulses: got %0d want %0d",
                     fe_pulses, exp_pulses);
        end
        step("release", 0, v);
        v = '{6'b110000, 7'b11_10000, 2'b01};
        step("resume", 0, v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
